// File: rtl/latch_write_ctrl.sv
// Write controller for a bank of transparent D latches: sequences D setup, E pulse and D hold
// for every accepted word, then reports completion with a pulse and a running count.
module latch_write_ctrl #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] lat_d,
    output logic             lat_e,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] wr_count
);

    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CB = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CB-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] lat_d_reg, lat_d_next;
    logic             lat_e_reg, lat_e_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [CNT_W-1:0] wr_count_reg, wr_count_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            lat_d_reg    <= '0;
            lat_e_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wr_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            lat_d_reg    <= lat_d_next;
            lat_e_reg    <= lat_e_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            wr_count_reg <= wr_count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        lat_d_next    = lat_d_reg;
        done_next     = 1'b0;
        wr_count_next = wr_count_reg;

        unique case (state_reg)
            IDLE: begin
                // D is only ever loaded here, so it cannot move while E is open
                if (in_valid) begin
                    lat_d_next = in_data;
                    state_next = SETUP;
                    cnt_next   = CB'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = PULSE;
                    cnt_next   = CB'(PULSE_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - CB'(1);
                end
            end
            PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                    cnt_next   = CB'(HOLD_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - CB'(1);
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    state_next    = IDLE;
                    done_next     = 1'b1;
                    wr_count_next = wr_count_reg + CNT_W'(1);
                end else begin
                    cnt_next = cnt_reg - CB'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // E and busy are registered decodes of the next state so they align with the state edges
        lat_e_next = (state_next == PULSE);
        busy_next  = (state_next != IDLE);
    end

    assign in_ready = (state_reg == IDLE) && !rst;
    assign lat_d    = lat_d_reg;
    assign lat_e    = lat_e_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Randomised scoreboard bench for latch_write_ctrl: a timeline model predicts every cycle,
// accepted writes are queued and popped by the monitor on each done pulse.
module tb_latch_write_ctrl;

    localparam int W = 8;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;
    localparam int T = S + P + H;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic [W-1:0] lat_d;
    logic         lat_e;
    logic         busy;
    logic         done;
    logic [15:0]  wr_count;

    latch_write_ctrl #(
        .WIDTH(W), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .lat_d(lat_d), .lat_e(lat_e), .busy(busy),
        .done(done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [15:0]  c;
    } exp_t;
    exp_t sb_q[$];

    // Reference timeline: m_e counts edges since the accepting edge of the write in flight
    bit           m_active = 1'b0;
    int           m_e = 0;
    logic [W-1:0] m_d = '0;
    logic [15:0]  m_cnt = '0;
    bit           preload_req = 1'b0;
    bit           rst_seen = 1'b0;
    bit           have_prev = 1'b0;
    logic [W-1:0] prev_d;
    logic         prev_e;
    logic         prev_busy;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge rst) rst_seen = 1'b1;

    always @(negedge clk) begin
        bit exp_busy, exp_done, exp_e;
        exp_t e;
        if (rst) begin
            m_active = 1'b0;
            m_e = 0;
            m_d = '0;
            m_cnt = '0;
            sb_q.delete();
        end
        if (preload_req) begin
            m_cnt = 16'hFFFF;
            preload_req = 1'b0;
        end
        exp_busy = m_active && (m_e < T);
        exp_done = m_active && (m_e == T);
        exp_e    = m_active && (m_e >= S) && (m_e < S + P);
        chk("busy", busy, exp_busy);
        chk("in_ready", in_ready, !exp_busy && !rst);
        chk("lat_e", lat_e, exp_e);
        chk("done", done, exp_done);
        chk("lat_d", lat_d, m_d);
        chk("wr_count", wr_count, m_cnt);

        if (done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done=1 expected no pending write at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_lat_d", lat_d, e.d);
                chk("sb_wr_count", wr_count, e.c);
            end
        end

        if (have_prev && !rst_seen && !rst) begin
            chk("e_d_same_edge", (lat_e !== prev_e) && (lat_d !== prev_d), 0);
            if (prev_busy && busy) chk("d_stable_busy", lat_d, prev_d);
        end
        rst_seen  = 1'b0;
        have_prev = 1'b1;
        prev_d    = lat_d;
        prev_e    = lat_e;
        prev_busy = busy;

        // Predict the next edge from the inputs the stimulus is holding now
        if (!rst) begin
            if (m_active && m_e < T) begin
                m_e++;
                if (m_e == T) m_cnt = m_cnt + 16'd1;
            end else if (in_valid) begin
                m_active = 1'b1;
                m_e = 0;
                m_d = in_data;
                sb_q.push_back('{d: in_data, c: m_cnt + 16'd1});
            end else begin
                m_active = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input bit drop);
        int  n = 0;
        bit  acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got no accept of 0x%0h expected accept within 50 cycles", d);
        end
        $display("write 0x%02h accepted at %0t", d, $time);
        if (drop) in_valid = 1'b0;
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single write
        send(8'hA5, 1'b1);
        tick(T + 2);

        // in_valid held high, data noise while busy
        send(8'h11, 1'b0);
        in_data = 8'($urandom);
        tick(1);
        in_data = 8'($urandom);
        send(8'h22, 1'b1);
        tick(T + 2);

        // Reset in PULSE, then a clean write straight after release
        send(8'h3C, 1'b1);
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        send(8'h7E, 1'b1);
        tick(T + 2);

        // Counter wrap
        force dut.wr_count_reg = 16'hFFFF;
        preload_req = 1'b1;
        #1;
        release dut.wr_count_reg;
        tick(1);
        send(8'h5A, 1'b1);
        tick(T + 2);

        for (int i = 0; i < 40; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                tick(1);
            end
            send(8'($urandom), 1'($urandom_range(0, 1)));
            if (i == 20) begin
                tick($urandom_range(0, 3));
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
        end

        in_valid = 1'b0;
        tick(T + 3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending writes expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
